// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
//   Shares a single uart_tx serialiser between N_REQ byte producers. Bytes are
//   granted one at a time in round-robin order. A requester can hold its
//   "line lock" to keep the grant across several bytes. An idle lock owner is
//   timed out after LOCK_TO cycles without a valid byte, so it cannot block
//   the other requesters for ever.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset (also resets uart_tx)
//   i_req_vld    per-requester byte valid
//   i_req_ch     per-requester byte, requester i at [8*i+7:8*i]
//   i_req_lock   requester i asks to keep the grant after its byte
//   o_req_rdy    byte accepted this cycle (onehot or zero, S_IDLE only)
//   o_gnt_id     index of the requester owning the current/last byte
//   o_busy       a byte is being issued or serialised
//   o_tx_ch_vld  one-cycle start pulse to uart_tx
//   o_tx_ch      byte to uart_tx, held from the pulse until tx_done
//   i_tx_done    one-cycle end-of-frame pulse from uart_tx
// -----------------------------------------------------------------------------
module uart_tx_arb #(
    parameter  int N_REQ   = 4,
    parameter  int LOCK_TO = 1024,
    localparam int IDW     = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     i_req_vld,
    input  logic [8*N_REQ-1:0]   i_req_ch,
    input  logic [N_REQ-1:0]     i_req_lock,
    output logic [N_REQ-1:0]     o_req_rdy,
    output logic [IDW-1:0]       o_gnt_id,
    output logic                 o_busy,
    output logic                 o_tx_ch_vld,
    output logic [7:0]           o_tx_ch,
    input  logic                 i_tx_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    // Counter wide enough to hold LOCK_TO without wrapping; kept at least
    // one bit wide so a disabled timeout still elaborates cleanly.
    localparam int              CW        = (LOCK_TO > 0) ? $clog2(LOCK_TO + 1) : 1;
    localparam logic [CW-1:0]   LOCK_LAST = (LOCK_TO > 0) ? CW'(LOCK_TO - 1) : '0;

    logic [1:0]      r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_gnt_id;
    logic [7:0]      r_tx_ch;
    logic            r_lock_own;
    logic [CW-1:0]   r_lock_cnt;

    logic            w_idle;
    logic            w_lock_act;
    logic            w_win_vld;
    logic [IDW-1:0]  w_win_id;
    logic [7:0]      w_win_ch;
    logic            w_hs;

    assign w_idle     = (r_state == S_IDLE);
    // The lock only counts while the owner still asserts its lock request.
    assign w_lock_act = r_lock_own & i_req_lock[r_ptr];

    // Winner selection. Under an active lock only the owner is eligible.
    // Otherwise search ptr+1, ptr+2, ... (mod N_REQ); iterating from the
    // farthest candidate down lets the nearest one overwrite the result.
    always_comb begin
        int v_idx;
        v_idx     = 0;
        w_win_vld = 1'b0;
        w_win_id  = '0;
        if (w_lock_act) begin
            w_win_vld = i_req_vld[r_ptr];
            w_win_id  = r_ptr;
        end else begin
            for (int k = N_REQ; k >= 1; k--) begin
                v_idx = (int'(r_ptr) + k) % N_REQ;
                if (i_req_vld[v_idx]) begin
                    w_win_vld = 1'b1;
                    w_win_id  = IDW'(v_idx);
                end
            end
        end
    end

    always_comb begin
        w_win_ch = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win_id == IDW'(i)) begin
                w_win_ch = i_req_ch[8*i +: 8];
            end
        end
    end

    assign w_hs = w_idle & w_win_vld;

    // rdy is combinational from req_vld; it is forced low while reset is
    // asserted so no requester believes a byte was taken during reset.
    always_comb begin
        o_req_rdy = '0;
        if (rst_n && w_hs) begin
            o_req_rdy[w_win_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= IDW'(N_REQ - 1);
            r_gnt_id   <= '0;
            r_tx_ch    <= 8'h00;
            r_lock_own <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        // A handshake takes precedence over a timeout in
                        // the same cycle; the lock follows the new byte.
                        r_tx_ch    <= w_win_ch;
                        r_gnt_id   <= w_win_id;
                        r_ptr      <= w_win_id;
                        r_lock_own <= i_req_lock[w_win_id];
                        r_lock_cnt <= '0;
                        r_state    <= S_SEND;
                    end else if (!i_req_lock[r_ptr]) begin
                        r_lock_own <= 1'b0;
                        r_lock_cnt <= '0;
                    end else if (w_lock_act && (LOCK_TO != 0)) begin
                        // Owner holds the lock but has nothing to send.
                        if (r_lock_cnt == LOCK_LAST) begin
                            r_lock_own <= 1'b0;
                            r_lock_cnt <= '0;
                        end else begin
                            r_lock_cnt <= r_lock_cnt + 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_tx_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_gnt_id    = r_gnt_id;
    assign o_busy      = ~w_idle;
    assign o_tx_ch_vld = (r_state == S_SEND);
    assign o_tx_ch     = r_tx_ch;

endmodule

// File: tb/tb_uart_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arb
//   Directed bench for uart_tx_arb (N_REQ=4, LOCK_TO=16). Inputs are driven on
//   the falling edge and outputs sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_uart_tx_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_vld;
    logic [31:0] req_ch;
    logic [3:0]  req_lock;
    logic [3:0]  req_rdy;
    logic [1:0]  gnt_id;
    logic        busy;
    logic        tx_ch_vld;
    logic [7:0]  tx_ch;
    logic        tx_done;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_arb #(
        .N_REQ   (4),
        .LOCK_TO (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_vld   (req_vld),
        .i_req_ch    (req_ch),
        .i_req_lock  (req_lock),
        .o_req_rdy   (req_rdy),
        .o_gnt_id    (gnt_id),
        .o_busy      (busy),
        .o_tx_ch_vld (tx_ch_vld),
        .o_tx_ch     (tx_ch),
        .i_tx_done   (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Called in S_WAIT on a falling edge; returns in S_IDLE on a falling edge.
    task automatic finish_frame();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    // One complete byte: grant check, start pulse, wait, frame end.
    task automatic issue(input string tag, input logic [1:0] exp_id,
                         input logic [7:0] exp_ch, input logic [3:0] exp_rdy);
        #1;
        check({tag, "_rdy"}, 32'(req_rdy), 32'(exp_rdy));
        tick();
        #1;
        check({tag, "_pulse"}, 32'(tx_ch_vld), 32'd1);
        check({tag, "_ch"}, 32'(tx_ch), 32'(exp_ch));
        check({tag, "_gnt"}, 32'(gnt_id), 32'(exp_id));
        tick();
        $display("byte %s: gnt=%0d ch=0x%02h", tag, gnt_id, tx_ch);
        finish_frame();
    endtask

    initial begin
        int bad;
        rst_n    = 1'b0;
        req_vld  = 4'b0000;
        req_ch   = 32'h0;
        req_lock = 4'b0000;
        tx_done  = 1'b0;

        // ---- 1: reset values, single requester, latency -------------------
        @(negedge clk);
        req_vld = 4'b0100;
        req_ch  = 32'h0041_0000;
        #1;
        check("rst_rdy", 32'(req_rdy), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_txch", 32'(tx_ch), 32'd0);
        check("rst_gnt", 32'(gnt_id), 32'd0);
        check("rst_pulse", 32'(tx_ch_vld), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("t1_rdy", 32'(req_rdy), 32'b0100);
        check("t1_nopulse", 32'(tx_ch_vld), 32'd0);
        tick();
        #1;
        check("t1_pulse", 32'(tx_ch_vld), 32'd1);
        check("t1_ch", 32'(tx_ch), 32'h41);
        check("t1_gnt", 32'(gnt_id), 32'd2);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_rdy_send", 32'(req_rdy), 32'd0);
        req_vld = 4'b0000;
        tx_done = 1'b1;          // must be ignored outside S_WAIT
        tick();
        tx_done = 1'b0;
        #1;
        check("t1_pulse_end", 32'(tx_ch_vld), 32'd0);
        check("t1_early_done", 32'(busy), 32'd1);
        check("t1_ch_hold", 32'(tx_ch), 32'h41);
        $display("byte t1: gnt=%0d ch=0x%02h", gnt_id, tx_ch);
        finish_frame();
        #1;
        check("t1_idle", 32'(busy), 32'd0);

        // ---- 2: round robin, all requesters valid ------------------------
        do_reset();
        req_vld  = 4'b1111;
        req_lock = 4'b0000;
        req_ch   = 32'h3332_3130;
        issue("t2_b0", 2'd0, 8'h30, 4'b0001);
        issue("t2_b1", 2'd1, 8'h31, 4'b0010);
        issue("t2_b2", 2'd2, 8'h32, 4'b0100);
        issue("t2_b3", 2'd3, 8'h33, 4'b1000);
        issue("t2_b4", 2'd0, 8'h30, 4'b0001);

        // ---- 3: line lock keeps req1 ---------------------------------------
        do_reset();
        req_vld  = 4'b0010;
        req_lock = 4'b0010;
        req_ch   = 32'h0000_4100;
        issue("t3_A", 2'd1, 8'h41, 4'b0010);
        req_vld  = 4'b1111;
        req_ch   = 32'h3332_4230;
        issue("t3_B", 2'd1, 8'h42, 4'b0010);
        req_ch   = 32'h3332_4330;
        issue("t3_C", 2'd1, 8'h43, 4'b0010);
        req_lock = 4'b0000;      // release: round robin resumes after req1
        issue("t3_rel", 2'd2, 8'h32, 4'b0100);
        issue("t3_nx3", 2'd3, 8'h33, 4'b1000);
        issue("t3_nx0", 2'd0, 8'h30, 4'b0001);

        // ---- 4: lock timeout after 16 idle cycles --------------------------
        do_reset();
        req_vld  = 4'b0010;
        req_lock = 4'b0010;
        req_ch   = 32'h0000_4C00;
        issue("t4_L", 2'd1, 8'h4C, 4'b0010);
        req_vld = 4'b1000;
        req_ch  = 32'h5200_0000;
        bad = 0;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (req_rdy !== 4'b0000) bad++;
            tick();
        end
        check("t4_held16", 32'(bad), 32'd0);
        #1;
        check("t4_rdy3", 32'(req_rdy), 32'b1000);
        tick();
        #1;
        check("t4_pulse", 32'(tx_ch_vld), 32'd1);
        check("t4_ch", 32'(tx_ch), 32'h52);
        check("t4_gnt", 32'(gnt_id), 32'd3);
        $display("byte t4: gnt=%0d ch=0x%02h", gnt_id, tx_ch);
        tick();

        // ---- 5: tx_done held off 100 cycles --------------------------------
        req_vld = 4'b1111;
        req_ch  = 32'h4443_4241;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (req_rdy !== 4'b0000 || tx_ch !== 8'h52 || busy !== 1'b1 || tx_ch_vld !== 1'b0)
                bad++;
            tick();
        end
        check("t5_stall_bad", 32'(bad), 32'd0);
        #1;
        check("t5_busy", 32'(busy), 32'd1);

        // ---- 6: reset in S_WAIT --------------------------------------------
        rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_rdy", 32'(req_rdy), 32'd0);
        check("t6_txch", 32'(tx_ch), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("t6_gnt", 32'(gnt_id), 32'd0);
        issue("t6_first", 2'd0, 8'h41, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
